// File: rtl/uart_core_pkg.sv
// uart_core_pkg
//   Shared constants and state types for the UART peripheral.
//   - Register map addresses (DATA / STATUS).
//   - STATUS bit positions.
//   - TX and RX state encodings.
package uart_core_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic UART_ADDR_DATA = 1'b0;
  localparam logic UART_ADDR_STAT = 1'b1;

  localparam int ST_TX_RDY = 0;
  localparam int ST_RX_VLD = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_FERR   = 3;
  localparam int ST_TX_BSY = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Receive path: 2-flop synchroniser on rxd, start-edge detect, mid-bit
//   sampling FSM and LSB-first shift register for 8N1 frames.
// Ports:
//   clk, rst   system clock, async active-high reset
//   rxd        serial input (asynchronous, idle high)
//   byte_done  one-cycle pulse when a frame has been completed
//   rx_byte    received byte, stable from byte_done until the next frame's data
//   stop_err   stop sample was 0 for the frame flagged by byte_done
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | waiting for a 1->0 edge on the synchronised line
// RX_START | half-bit wait, then confirm start bit still low (else glitch)
// RX_DATA  | sample one data bit every full bit time, 8 bits LSB first
// RX_STOP  | sample the stop bit mid-bit, report byte and stop error
module uart_rx_deser
  import uart_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              byte_done,
  output logic [DATA_W-1:0] rx_byte,
  output logic              stop_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              rx_meta, rx_sync, rx_prev;
  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              done_n, err_n;

  // rx_prev lets IDLE see a true high-to-low transition rather than a low level,
  // so a line left low by a bad stop bit does not retrigger reception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      byte_done <= done_n;
      stop_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    err_n   = stop_err;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n = RX_START;
          cnt_n   = HALF_BIT;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (rx_sync) begin
            state_n = RX_IDLE;
          end else begin
            state_n = RX_DATA;
            cnt_n   = FULL_BIT;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_sync, shreg[DATA_W-1:1]};
          cnt_n   = FULL_BIT;
          if (idx == LAST_IDX) state_n = RX_STOP;
          else                 idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          done_n  = 1'b1;
          err_n   = !rx_sync;
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/uart_core.sv
// uart_core
//   Bus-slave 8N1 UART with a two-register map (DATA at 0, STATUS at 1).
//   Contains the TX FSM, the single-entry TX hold register and the RX status
//   register file; the receive deserialiser lives in uart_rx_deser.
// Ports:
//   clk, rst   system clock, async active-high reset
//   uart_rd    read strobe (side effects at the clock edge)
//   uart_wr    write strobe
//   uart_addr  0 = DATA, 1 = STATUS
//   uart_din   write data
//   uart_dout  read data, combinational from uart_addr and register state
//   rxd        serial input, idle high
//   txd        serial output, idle high
//
// state    | meaning
// ---------+-------------------------------------------------------------
// TX_IDLE  | line high; pull a byte from the hold register when present
// TX_START | start bit (low) for one bit time
// TX_DATA  | 8 data bits, LSB first, one bit time each
// TX_STOP  | stop bit (high); chain straight into the next start if held
module uart_core
  import uart_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rd,
  input  logic              uart_wr,
  input  logic              uart_addr,
  input  logic [DATA_W-1:0] uart_din,
  output logic [DATA_W-1:0] uart_dout,
  input  logic              rxd,
  output logic              txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // TX
  tx_state_t         tx_state, tx_state_n;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]  tx_idx, tx_idx_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              txd_n;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic              take_hold;
  logic              wr_accept;

  // RX register file
  logic              byte_done, stop_err;
  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, overrun, frame_err;
  logic              rd_data, rd_stat, rx_accept;
  logic [DATA_W-1:0] status;

  assign wr_accept = uart_wr && (uart_addr == UART_ADDR_DATA) && !hold_full;

  // take_hold and wr_accept are mutually exclusive: one needs the hold full,
  // the other needs it empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (take_hold) begin
      hold_full <= 1'b0;
    end else if (wr_accept) begin
      hold      <= uart_din;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    take_hold  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (hold_full) begin
          take_hold  = 1'b1;
          tx_shift_n = hold;
          tx_state_n = TX_START;
          tx_cnt_n   = FULL_BIT;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = FULL_BIT;
          tx_idx_n   = '0;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = FULL_BIT;
          if (tx_idx == LAST_IDX) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_idx_n   = tx_idx + IDX_W'(1);
            tx_shift_n = tx_shift >> 1;
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (hold_full) begin
            take_hold  = 1'b1;
            tx_shift_n = hold;
            tx_state_n = TX_START;
            tx_cnt_n   = FULL_BIT;
            txd_n      = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
      end
    endcase
  end

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .byte_done(byte_done),
    .rx_byte  (rx_byte),
    .stop_err (stop_err)
  );

  assign rd_data   = uart_rd && (uart_addr == UART_ADDR_DATA);
  assign rd_stat   = uart_rd && (uart_addr == UART_ADDR_STAT);
  // A DATA read in the completion cycle frees the slot, so the new byte lands.
  assign rx_accept = byte_done && (!rx_valid || rd_data);

  // Sets are checked before clears so a new event wins over a coincident read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_accept) rx_data <= rx_byte;

      if (rx_accept)    rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;

      if (byte_done && !rx_accept) overrun <= 1'b1;
      else if (rd_stat)            overrun <= 1'b0;

      if (byte_done && stop_err) frame_err <= 1'b1;
      else if (rd_stat)          frame_err <= 1'b0;
    end
  end

  always_comb begin
    status            = '0;
    status[ST_TX_RDY] = !hold_full;
    status[ST_RX_VLD] = rx_valid;
    status[ST_OVR]    = overrun;
    status[ST_FERR]   = frame_err;
    status[ST_TX_BSY] = (tx_state != TX_IDLE);
  end

  assign uart_dout = (uart_addr == UART_ADDR_STAT) ? status : rx_data;

endmodule
